matrix_fbuf: RTL

//  Double-buffered (ping-pong) frame store feeding the 32x16 RGB LED matrix scanner.

---
 rtl/matrix_fbuf.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/matrix_fbuf.sv
// Ping-pong frame store between a raster pixel writer and the 32x16 RGB matrix scanner.
// Optional FBUF_CLEAR_EN: zero both buffers after reset release before accepting pixels.
module matrix_fbuf #(
    parameter int unsigned NCOL  = 32,
    parameter int unsigned NSCAN = 8,
    parameter int unsigned CW    = $clog2(NCOL),
    parameter int unsigned RW    = $clog2(NSCAN)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          wr_valid_i,
    output logic          wr_ready_o,
    input  logic          wr_sof_i,
    input  logic [2:0]    wr_rgb_i,
    input  logic          frame_done_i,
    input  logic [CW-1:0] col_i,
    input  logic [RW-1:0] row_i,
    output logic          r1_o,
    output logic          g1_o,
    output logic          b1_o,
    output logic          r2_o,
    output logic          g2_o,
    output logic          b2_o,
    output logic          front_sel_o,
    output logic          swapped_o
);

    localparam int unsigned DEPTH = NSCAN * NCOL;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam logic [CW-1:0] ColLast = CW'(NCOL - 1);
    localparam logic [RW:0]   RowLast = (RW + 1)'(2 * NSCAN - 1);

    typedef enum logic [1:0] {StClear, StFill, StFull} state_e;

    state_e        state_q;
    logic          front_sel_q;
    logic          swapped_q;
    logic          wr_ready_q;
    logic [CW-1:0] wcol_q, wcol_d;
    logic [RW:0]   wrow_q, wrow_d;
`ifdef FBUF_CLEAR_EN
    logic [AW-1:0] clr_q;
`endif

    logic [2:0] top_mem [2][DEPTH];
    logic [2:0] bot_mem [2][DEPTH];

    logic [2:0] rd_top_q, rd_bot_q;

    // Write-side address decode; a start-of-frame pixel always lands at (0,0).
    logic          wr_fire;
    logic          wr_bot;
    logic          wr_last;
    logic [CW-1:0] eff_col;
    logic [RW:0]   eff_row;
    logic [AW-1:0] wr_idx;
    int unsigned   loc_row;

    always_comb begin
        wr_fire = wr_valid_i && wr_ready_q;
        eff_col = wr_sof_i ? '0 : wcol_q;
        eff_row = wr_sof_i ? '0 : wrow_q;
        wr_bot  = 32'(eff_row) >= NSCAN;
        loc_row = wr_bot ? 32'(eff_row) - NSCAN : 32'(eff_row);
        wr_idx  = AW'(loc_row * NCOL + 32'(eff_col));
        wr_last = (eff_row == RowLast) && (eff_col == ColLast);
        if (eff_col == ColLast) begin
            wcol_d = '0;
            wrow_d = eff_row + 1'b1;
        end else begin
            wcol_d = eff_col + 1'b1;
            wrow_d = eff_row;
        end
    end

    // Read-side decode; out-of-range coordinates read as black.
    logic          rd_ok;
    logic [AW-1:0] rd_idx;

    always_comb begin
        rd_ok  = (32'(col_i) < NCOL) && (32'(row_i) < NSCAN);
        rd_idx = rd_ok ? AW'(32'(row_i) * NCOL + 32'(col_i)) : '0;
    end

    // Control FSM with registered handshake and status outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
`ifdef FBUF_CLEAR_EN
            state_q    <= StClear;
            wr_ready_q <= 1'b0;
            clr_q      <= '0;
`else
            state_q    <= StFill;
            wr_ready_q <= 1'b1;
`endif
            front_sel_q <= 1'b0;
            swapped_q   <= 1'b0;
            wcol_q      <= '0;
            wrow_q      <= '0;
        end else begin
            swapped_q <= 1'b0;
            unique case (state_q)
`ifdef FBUF_CLEAR_EN
                StClear: begin
                    clr_q <= clr_q + 1'b1;
                    if (clr_q == AW'(DEPTH - 1)) begin
                        clr_q      <= '0;
                        state_q    <= StFill;
                        wr_ready_q <= 1'b1;
                    end
                end
`endif
                StFill: begin
                    // frame_done is ignored here, even alongside the last pixel.
                    if (wr_fire) begin
                        if (wr_last) begin
                            state_q    <= StFull;
                            wr_ready_q <= 1'b0;
                            wcol_q     <= '0;
                            wrow_q     <= '0;
                        end else begin
                            wcol_q <= wcol_d;
                            wrow_q <= wrow_d;
                        end
                    end
                end
                StFull: begin
                    if (frame_done_i) begin
                        front_sel_q <= ~front_sel_q;
                        state_q     <= StFill;
                        wr_ready_q  <= 1'b1;
                        swapped_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= StFill;
                    wr_ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Frame memories are not reset; the writer only ever touches the back buffer.
    always_ff @(posedge clk_i) begin
`ifdef FBUF_CLEAR_EN
        if (state_q == StClear) begin
            for (int b = 0; b < 2; b++) begin
                top_mem[b][clr_q] <= 3'b000;
                bot_mem[b][clr_q] <= 3'b000;
            end
        end else
`endif
        if (wr_fire) begin
            if (wr_bot) begin
                bot_mem[~front_sel_q][wr_idx] <= wr_rgb_i;
            end else begin
                top_mem[~front_sel_q][wr_idx] <= wr_rgb_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_top_q <= 3'b000;
            rd_bot_q <= 3'b000;
        end else begin
            rd_top_q <= rd_ok ? top_mem[front_sel_q][rd_idx] : 3'b000;
            rd_bot_q <= rd_ok ? bot_mem[front_sel_q][rd_idx] : 3'b000;
        end
    end

    assign wr_ready_o  = wr_ready_q;
    assign front_sel_o = front_sel_q;
    assign swapped_o   = swapped_q;
    assign {r1_o, g1_o, b1_o} = rd_top_q;
    assign {r2_o, g2_o, b2_o} = rd_bot_q;

    a_ready_fill: assert property (@(posedge clk_i) disable iff (!rst_ni)
        wr_ready_q == (state_q == StFill));
    a_swap_pulse: assert property (@(posedge clk_i) disable iff (!rst_ni)
        swapped_q |=> !swapped_q);

endmodule
